// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcodes, one-hot sequencer
// state encodings and the sequencer FSM state type.
package cpu_pkg;

   localparam int unsigned INST_W  = 4;
   localparam int unsigned STATE_W = 3;

   localparam logic [INST_W-1:0] OP_STA = 4'b0010;
   localparam logic [INST_W-1:0] OP_JMP = 4'b0011;
   localparam logic [INST_W-1:0] OP_STP = 4'b0100;
   localparam logic [INST_W-1:0] OP_LDA = 4'b0101;
   localparam logic [INST_W-1:0] OP_JMS = 4'b0110;
   localparam logic [INST_W-1:0] OP_BBL = 4'b0111;
   localparam logic [INST_W-1:0] OP_LDR = 4'b1101;
   localparam logic [INST_W-2:0] OP_JEQ_PFX = 3'b000;

   localparam logic [STATE_W-1:0] ST_NONE  = 3'b000;
   localparam logic [STATE_W-1:0] ST_FETCH = 3'b001;
   localparam logic [STATE_W-1:0] ST_EXEC1 = 3'b010;
   localparam logic [STATE_W-1:0] ST_EXEC2 = 3'b100;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_FETCH,
      SEQ_EXEC1,
      SEQ_EXEC2,
      SEQ_HALT
   } seq_state_e;

   // Decoder-facing one-hot view of an FSM state; IDLE and HALT both read 000.
   function automatic logic [STATE_W-1:0] state_onehot(input seq_state_e s);
      logic [STATE_W-1:0] v;
      v = ST_NONE;
      case (s)
         SEQ_FETCH: v = ST_FETCH;
         SEQ_EXEC1: v = ST_EXEC1;
         SEQ_EXEC2: v = ST_EXEC2;
         default:   v = ST_NONE;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/ret_stack.sv
// Subroutine return-address stack. Full/empty requests are ignored here;
// the sequencer turns them into overflow/underflow faults.
module ret_stack
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W  = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [PC_W-1:0]          din,
   output logic [PC_W-1:0]          top,
   output logic [$clog2(DEPTH):0]   sp,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned SP_W = AW + 1;

   logic [PC_W-1:0] r_mem [DEPTH];
   logic [SP_W-1:0] r_sp;
   logic [AW-1:0]   w_top_idx;
   logic            w_do_push;
   logic            w_do_pop;

   assign full      = (r_sp == SP_W'(DEPTH));
   assign empty     = (r_sp == SP_W'(0));
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign w_top_idx = AW'(r_sp - SP_W'(1));
   assign top       = r_mem[w_top_idx];
   assign sp        = r_sp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sp <= SP_W'(0);
      end else if (w_do_push) begin
         r_sp <= r_sp + SP_W'(1);
      end else if (w_do_pop) begin
         r_sp <= r_sp - SP_W'(1);
      end
   end

   // Storage is not reset; a push on the reset edge must not land.
   always_ff @(posedge clk) begin
      if (!rst && w_do_push) begin
         r_mem[r_sp[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/exec1/exec2 sequencer with run/step/halt control and the JMS/BBL
// return-address stack, including overflow/underflow halting.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W  = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic                     step,
   input  logic [3:0]               inst,
   input  logic [PC_W-1:0]          pc,
   output logic [2:0]               state,
   output logic                     halted,
   output logic                     call_load,
   output logic                     ret_load,
   output logic [PC_W-1:0]          ret_addr,
   output logic [$clog2(DEPTH):0]   sp,
   output logic                     inst_done,
   output logic                     stk_ovf,
   output logic                     stk_unf
);

   seq_state_e       r_state;
   seq_state_e       w_next;
   logic             r_run_mode;
   logic             w_next_run_mode;
   logic [2:0]       r_state_vec;
   logic             r_halted;
   logic             r_stk_ovf;
   logic             r_stk_unf;

   logic             w_push;
   logic             w_pop;
   logic             w_call_load;
   logic             w_ret_load;
   logic             w_inst_done;
   logic             w_set_ovf;
   logic             w_set_unf;
   logic             w_full;
   logic             w_empty;
   logic [PC_W-1:0]  w_push_data;

   assign w_push_data = PC_W'(pc + PC_W'(1));

   ret_stack #(
      .PC_W  (PC_W),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_push_data),
      .top   (ret_addr),
      .sp    (sp),
      .full  (w_full),
      .empty (w_empty)
   );

   // State register; one-hot view and halt flag are registered alongside.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= SEQ_IDLE;
         r_run_mode  <= 1'b0;
         r_state_vec <= ST_NONE;
         r_halted    <= 1'b0;
         r_stk_ovf   <= 1'b0;
         r_stk_unf   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_run_mode  <= w_next_run_mode;
         r_state_vec <= state_onehot(w_next);
         r_halted    <= (w_next == SEQ_HALT);
         r_stk_ovf   <= r_stk_ovf | w_set_ovf;
         r_stk_unf   <= r_stk_unf | w_set_unf;
      end
   end

   // Next-state, stack control and PC-load strobes.
   always_comb begin
      w_next          = r_state;
      w_next_run_mode = r_run_mode;
      w_push          = 1'b0;
      w_pop           = 1'b0;
      w_call_load     = 1'b0;
      w_ret_load      = 1'b0;
      w_inst_done     = 1'b0;
      w_set_ovf       = 1'b0;
      w_set_unf       = 1'b0;

      case (r_state)
         SEQ_IDLE: begin
            if (run) begin
               w_next          = SEQ_FETCH;
               w_next_run_mode = 1'b1;
            end else if (step) begin
               w_next          = SEQ_FETCH;
               w_next_run_mode = 1'b0;
            end
         end
         SEQ_FETCH: begin
            w_next = SEQ_EXEC1;
         end
         SEQ_EXEC1: begin
            if (inst == OP_STP) begin
               w_next      = SEQ_HALT;
               w_inst_done = 1'b1;
            end else if (inst == OP_JMS) begin
               if (w_full) begin
                  w_set_ovf = 1'b1;
                  w_next    = SEQ_HALT;
               end else begin
                  w_push      = 1'b1;
                  w_call_load = 1'b1;
                  w_next      = SEQ_EXEC2;
               end
            end else if (inst == OP_BBL) begin
               if (w_empty) begin
                  w_set_unf = 1'b1;
                  w_next    = SEQ_HALT;
               end else begin
                  w_pop      = 1'b1;
                  w_ret_load = 1'b1;
                  w_next     = SEQ_EXEC2;
               end
            end else begin
               w_next = SEQ_EXEC2;
            end
         end
         SEQ_EXEC2: begin
            w_inst_done = 1'b1;
            if (r_run_mode && run) begin
               w_next = SEQ_FETCH;
            end else begin
               w_next = SEQ_IDLE;
            end
         end
         SEQ_HALT: begin
            w_next = SEQ_HALT;
         end
         default: begin
            w_next = SEQ_IDLE;
         end
      endcase
   end

   assign state     = r_state_vec;
   assign halted    = r_halted;
   assign stk_ovf   = r_stk_ovf;
   assign stk_unf   = r_stk_unf;
   assign call_load = w_call_load;
   assign ret_load  = w_ret_load;
   assign inst_done = w_inst_done;

endmodule
